// File: rtl/imm_pkg.sv
// Immediate-format encodings and datapath-width legality shared by the immediate generator.
package imm_pkg;

  localparam logic [2:0] I_T   = 3'b000;
  localparam logic [2:0] S_T   = 3'b001;
  localparam logic [2:0] B_T   = 3'b010;
  localparam logic [2:0] J_T   = 3'b011;
  localparam logic [2:0] U_T   = 3'b100;
  localparam logic [2:0] Z_T   = 3'b101;
  localparam logic [2:0] SH_T  = 3'b110;
  localparam logic [2:0] ILL_T = 3'b111;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode: builds the 32-bit immediate, then sign-extends to XLEN.
// Latency 0; no flow control.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  logic        s;
  logic [31:0] imm32;

  assign s = instr_i[31];

  always_comb begin
    imm32 = '0;
    err_o = 1'b0;
    case (immsrc_i)
      I_T:  imm32 = {{20{s}}, instr_i[31:20]};
      S_T:  imm32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      B_T:  imm32 = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      J_T:  imm32 = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      U_T:  imm32 = {instr_i[31:12], 12'b0};
      Z_T:  imm32 = {27'b0, instr_i[19:15]};
      SH_T: begin
        if (XLEN == 64) imm32 = {26'b0, instr_i[25:20]};
        else            imm32 = {27'b0, instr_i[24:20]};
      end
      default: err_o = 1'b1;
    endcase
  end

  // Z and SH never set bit 31, so one sign extension serves every format.
  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_extract: XLEN must be 32 or 64");
  end else if (XLEN == 64) begin : g_x64
    assign imm_o = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm_o = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: 1-cycle latency, output register plus one skid entry.
// in_ready is registered (skid empty), so out_ready has no combinational path to in_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [XLEN-1:0]  ext_imm;
  logic             ext_err;

  logic             out_vld_q, out_vld_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;

  logic             skid_vld_q, skid_vld_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;

  logic             accept;
  logic             out_free;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i  (in_instr),
    .immsrc_i (in_immsrc),
    .imm_o    (ext_imm),
    .err_o    (ext_err)
  );

  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_vld_q || out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    out_err_d  = out_err_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_err_d = skid_err_q;
    if (out_free) begin
      // The skid entry is older than anything on the input, so it drains first.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_imm_d  = skid_imm_q;
        out_tag_d  = skid_tag_q;
        out_err_d  = skid_err_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d = 1'b1;
        out_imm_d = ext_imm;
        out_tag_d = in_tag;
        out_err_d = ext_err;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_imm_d = ext_imm;
      skid_tag_d = in_tag;
      skid_err_d = ext_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_err_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_err_q  <= out_err_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance, each checked every cycle
// against an arithmetic reference model, plus directed literal expectations.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_instr  [2];
  logic [2:0]  in_immsrc [2];
  logic [7:0]  in_tag    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [63:0] out_imm   [2];
  logic [7:0]  out_tag   [2];
  logic        out_err   [2];
  logic [31:0] imm32;
  logic [63:0] imm64;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  assign out_imm[0] = {32'b0, imm32};
  assign out_imm[1] = imm64;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_instr(in_instr[0]),
    .in_immsrc(in_immsrc[0]), .in_tag(in_tag[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_imm(imm32),
    .out_tag(out_tag[0]), .out_err(out_err[0])
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_instr(in_instr[1]),
    .in_immsrc(in_immsrc[1]), .in_tag(in_tag[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_imm(imm64),
    .out_tag(out_tag[1]), .out_err(out_err[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference immediate: value arithmetic on the instruction fields, truncated to XLEN.
  function automatic logic [63:0] model(input int xl, input logic [31:0] ins, input logic [2:0] src);
    longint v;
    longint sgn;
    sgn = ins[31] ? -64'sd1 : 64'sd0;
    case (src)
      3'd0: v = longint'($signed(ins)) >>> 20;
      3'd1: v = (longint'($signed(ins)) >>> 25) * 32 + longint'(ins[11:7]);
      3'd2: v = sgn * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                + longint'(ins[11:8]) * 2;
      3'd3: v = sgn * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2;
      3'd4: v = longint'($signed(ins & 32'hFFFF_F000));
      3'd5: v = longint'(ins[19:15]);
      3'd6: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    if (xl == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    exp_t       q[$];
    logic [7:0] ctag[$];
    int         ccyc[$];
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (out_valid[g]) begin
          if (q.size() == 0) begin
            chk($sformatf("x%0d_unexpected_valid", g), 64'(out_valid[g]), 64'd0);
          end else begin
            chk($sformatf("x%0d_model_imm", g), out_imm[g], q[0].imm);
            chk($sformatf("x%0d_model_tag", g), 64'(out_tag[g]), 64'(q[0].tag));
            chk($sformatf("x%0d_model_err", g), 64'(out_err[g]), 64'(q[0].err));
            if (out_ready[g]) begin
              ctag.push_back(out_tag[g]);
              ccyc.push_back(cyc);
              void'(q.pop_front());
            end
          end
        end
        if (in_valid[g] && in_ready[g])
          q.push_back('{model(g == 0 ? 32 : 64, in_instr[g], in_immsrc[g]),
                        in_tag[g], in_immsrc[g] == ILL_T});
      end
    end
  end

  task automatic drive(input int k, input logic [31:0] ins, input logic [2:0] src,
                       input logic [7:0] tag);
    in_valid[k]  = 1'b1;
    in_instr[k]  = ins;
    in_immsrc[k] = src;
    in_tag[k]    = tag;
  endtask

  // Hold the current request until a rising edge sees in_ready, then drop in_valid.
  task automatic wait_accept(input int k, input string nm);
    int n = 0;
    bit ok;
    do begin
      @(negedge clk);
      ok = in_ready[k];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    in_valid[k] = 1'b0;
    if (!ok) chk({nm, "_accept_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic send(input int k, input logic [31:0] ins, input logic [2:0] src,
                      input logic [7:0] tag, input string nm);
    @(posedge clk);
    #1;
    drive(k, ins, src, tag);
    wait_accept(k, nm);
  endtask

  task automatic send_chk(input int k, input logic [31:0] ins, input logic [2:0] src,
                          input logic [7:0] tag, input logic [63:0] exp_imm,
                          input logic exp_err, input string nm);
    send(k, ins, src, tag, nm);
    @(negedge clk);
    chk({nm, "_vld"}, 64'(out_valid[k]), 64'd1);
    chk({nm, "_imm"}, out_imm[k], exp_imm);
    chk({nm, "_tag"}, 64'(out_tag[k]), 64'(tag));
    chk({nm, "_err"}, 64'(out_err[k]), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_instr[k] = '0; in_immsrc[k] = '0;
      in_tag[k] = '0; out_ready[k] = 1'b1;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("x%0d_rst_out_valid", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("x%0d_rst_in_ready", k), 64'(in_ready[k]), 64'd1);
      chk($sformatf("x%0d_rst_out_imm", k), out_imm[k], 64'd0);
      chk($sformatf("x%0d_rst_out_tag", k), 64'(out_tag[k]), 64'd0);
      chk($sformatf("x%0d_rst_out_err", k), 64'(out_err[k]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // RV32 formats
    send_chk(0, 32'hFFF00093, I_T, 8'h11, 64'hFFFF_FFFF, 1'b0, "x32_I");
    send_chk(0, 32'hFE20AE23, S_T, 8'h12, 64'hFFFF_FFFC, 1'b0, "x32_S");
    send_chk(0, 32'hFE000CE3, B_T, 8'h13, 64'hFFFF_FFF8, 1'b0, "x32_B");
    send_chk(0, 32'h0010006F, J_T, 8'h14, 64'h0000_0800, 1'b0, "x32_J");
    send_chk(0, 32'h123452B7, U_T, 8'h15, 64'h1234_5000, 1'b0, "x32_U");
    send_chk(0, 32'h03F00013, SH_T, 8'h16, 64'h1F, 1'b0, "x32_SH");

    // RV64 formats
    send_chk(1, 32'h800002B7, U_T, 8'h21, 64'hFFFF_FFFF_8000_0000, 1'b0, "x64_U");
    send_chk(1, 32'h03F00013, SH_T, 8'h22, 64'h3F, 1'b0, "x64_SH");
    send_chk(1, 32'h000F8073, Z_T, 8'h23, 64'h1F, 1'b0, "x64_Z");
    send_chk(1, 32'hFFF00093, I_T, 8'h24, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "x64_I");
    send_chk(1, 32'hFE000CE3, B_T, 8'h25, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, "x64_B");

    // Illegal format, then recovery
    send_chk(0, 32'hFFFF_FFFF, ILL_T, 8'hAB, 64'd0, 1'b1, "x32_ill");
    send_chk(0, 32'h00500093, I_T, 8'hAC, 64'd5, 1'b0, "x32_after_ill");

    // Back-pressure: three back-to-back requests against a stalled output
    @(posedge clk);
    #1;
    mon[0].ctag.delete();
    mon[0].ccyc.delete();
    out_ready[0] = 1'b0;
    drive(0, 32'h00100093, I_T, 8'd1);
    @(posedge clk); #1;
    drive(0, 32'h00200093, I_T, 8'd2);
    @(posedge clk); #1;
    drive(0, 32'h00300093, I_T, 8'd3);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_held", 64'(in_ready[0]), 64'd0);
    chk("bp_held_tag", 64'(out_tag[0]), 64'd1);
    chk("bp_held_imm", out_imm[0], 64'd1);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_accept(0, "bp_tag3");
    repeat (3) @(negedge clk);
    chk("bp_consumed_count", 64'(mon[0].ctag.size()), 64'd3);
    if (mon[0].ctag.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp_order_%0d", i), 64'(mon[0].ctag[i]), 64'(i + 1));
      chk("bp_no_gap_12", 64'(mon[0].ccyc[1] - mon[0].ccyc[0]), 64'd1);
      chk("bp_no_gap_23", 64'(mon[0].ccyc[2] - mon[0].ccyc[1]), 64'd1);
    end

    // Reset with two entries held
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    drive(0, 32'h00700093, I_T, 8'h31);
    @(posedge clk); #1;
    drive(0, 32'h00800093, I_T, 8'h32);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("rst_mid_in_ready_before", 64'(in_ready[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rst_mid_out_tag", 64'(out_tag[0]), 64'd0);
    chk("rst_mid_out_imm", out_imm[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_stale_valid", 64'(out_valid[0]), 64'd0);
    end
    send_chk(0, 32'hFFE00093, I_T, 8'h41, 64'hFFFF_FFFE, 1'b0, "x32_after_rst");

    repeat (3) @(negedge clk);
    chk("x32_queue_drained", 64'(mon[0].q.size()), 64'd0);
    chk("x64_queue_drained", 64'(mon[1].q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
